regfile_mp: RTL and testbench

Parametrised multi-port general register file for the MIPS CPU datapath. It replaces the fixed 32×32, two-read/one-write register file. It adds:
- configurable width, depth and read-port count;
- a second write port, so a late pipeline stage and an early pipeline stage can retire in the same cycle;
- an optional write-to-read bypass;
- a per-register busy scoreboard that the hazard unit uses for stall decisions.

It sits between decode (read/busy query) and write-back (writes).

---
 rtl/regfile_mp.sv | 94 +++++++++
 tb/tb_regfile_mp.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with write bypass and busy scoreboard
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [WIDTH-1:0]     wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [WIDTH-1:0]     wd1,
    input  logic                 set_busy,
    input  logic [AW-1:0]        set_addr,
    output logic [DEPTH-1:0]     busy_vec
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] clr_mask;
    logic [DEPTH-1:0] set_mask;
    logic             wr0_ok;
    logic             wr1_ok;
    logic             set_ok;

    assign wr0_ok = we0 && !(ZERO_REG && (wa0 == '0));
    assign wr1_ok = we1 && !(ZERO_REG && (wa1 == '0));
    assign set_ok = set_busy && !(ZERO_REG && (set_addr == '0));

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wr0_ok) clr_mask[wa0] = 1'b1;
        if (wr1_ok) clr_mask[wa1] = 1'b1;
        if (set_ok) set_mask[set_addr] = 1'b1;
    end

    // Set is applied after clear so a newly issued producer wins over a retiring write.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr0_ok && !(wr1_ok && (wa1 == wa0))) regs[wa0] <= wd0;
            if (wr1_ok) regs[wa1] <= wd1;
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign busy_vec = busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    addr;
        logic             hit0;
        logic             hit1;
        logic             set_hit;
        logic [WIDTH-1:0] data;
        logic             bsy;

        assign addr    = rd_addr[k*AW +: AW];
        assign hit0    = we0 && (wa0 == addr);
        assign hit1    = we1 && (wa1 == addr);
        assign set_hit = set_busy && (set_addr == addr);

        // With bypass the busy flag reports the state the scoreboard will hold after the edge.
        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
            if (ZERO_REG && (addr == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end else if (BYPASS) begin
                if (hit1) begin
                    data = wd1;
                end else if (hit0) begin
                    data = wd0;
                end
                bsy = (busy[addr] && !(hit0 || hit1)) || set_hit;
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = data;
        assign rd_busy[k]                = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp in bypass, no-bypass and wide configurations
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_we0, a_we1, a_set_busy;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [4:0]  a_wa0, a_wa1, a_set_addr;
    logic [31:0] a_wd0, a_wd1, a_busy_vec;

    logic        b_reset, b_we0, b_we1, b_set_busy;
    logic [9:0]  b_rd_addr;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [4:0]  b_wa0, b_wa1, b_set_addr;
    logic [31:0] b_wd0, b_wd1, b_busy_vec;

    logic         c_reset, c_we0, c_we1, c_set_busy;
    logic [11:0]  c_rd_addr;
    logic [191:0] c_rd_data;
    logic [2:0]   c_rd_busy;
    logic [3:0]   c_wa0, c_wa1, c_set_addr;
    logic [63:0]  c_wd0, c_wd1;
    logic [15:0]  c_busy_vec;

    regfile_mp u_a (
        .clk(clk), .Reset(a_reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0), .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
        .set_busy(a_set_busy), .set_addr(a_set_addr), .busy_vec(a_busy_vec)
    );

    regfile_mp #(.BYPASS(1'b0)) u_b (
        .clk(clk), .Reset(b_reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
        .set_busy(b_set_busy), .set_addr(b_set_addr), .busy_vec(b_busy_vec)
    );

    regfile_mp #(.WIDTH(64), .DEPTH(16), .NRD(3)) u_c (
        .clk(clk), .Reset(c_reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0), .we1(c_we1), .wa1(c_wa1), .wd1(c_wd1),
        .set_busy(c_set_busy), .set_addr(c_set_addr), .busy_vec(c_busy_vec)
    );

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    function automatic exp_t mk(input string n, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        return e;
    endfunction

    // Reference behaviour of the default instance, written from the read/write/busy rules.
    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a_we1 && a_wa1 == a) return a_wd1;
        if (a_we0 && a_wa0 == a) return a_wd0;
        return m_mem[a];
    endfunction

    function automatic logic m_rb(input logic [4:0] a);
        logic wr;
        if (a == 5'd0) return 1'b0;
        wr = (a_we0 && a_wa0 == a) || (a_we1 && a_wa1 == a);
        return (m_busy[a] && !wr) || (a_set_busy && a_set_addr == a);
    endfunction

    task automatic m_edge();
        if (a_reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
            m_busy = 32'd0;
        end else begin
            if (a_we0 && a_wa0 != 5'd0) m_mem[a_wa0] = a_wd0;
            if (a_we1 && a_wa1 != 5'd0) m_mem[a_wa1] = a_wd1;
            if (a_we0) m_busy[a_wa0] = 1'b0;
            if (a_we1) m_busy[a_wa1] = 1'b0;
            if (a_set_busy && a_set_addr != 5'd0) m_busy[a_set_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_we0 = 0; a_we1 = 0; a_set_busy = 0;
        b_we0 = 0; b_we1 = 0; b_set_busy = 0;
        c_we0 = 0; c_we1 = 0; c_set_busy = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [63:0] obs;
        a_reset = 1; b_reset = 1; c_reset = 1;
        tick();
        a_reset = 0; b_reset = 0; c_reset = 0;
        sb.push_back(mk("busy_vec_after_reset", 64'd0));
        e = sb.pop_front(); obs = 64'(a_busy_vec); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        for (int i = 0; i < 32; i++) begin
            a_rd_addr = {5'(31 - i), 5'(i)};
            sb.push_back(mk("reset_rd0", 64'd0));
            sb.push_back(mk("reset_rd1", 64'd0));
            #2;
            for (int k = 0; k < 2; k++) begin
                e = sb.pop_front(); obs = 64'(a_rd_data[k*32 +: 32]); checks++;
                if (obs !== e.val) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, i, obs, e.val); end
            end
            tick();
        end
        a_we0 = 1; a_wa0 = 5'd5; a_wd0 = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        a_rd_addr = {5'd0, 5'd5};
        sb.push_back(mk("write_reg5", 64'hDEAD_BEEF));
        #2;
        e = sb.pop_front(); obs = 64'(a_rd_data[31:0]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        logic [63:0] obs;
        a_we0 = 1; a_wa0 = 5'd0; a_wd0 = 32'h1234_5678;
        a_we1 = 1; a_wa1 = 5'd0; a_wd1 = 32'h1234_5678;
        a_set_busy = 1; a_set_addr = 5'd0;
        a_rd_addr = {5'd0, 5'd0};
        sb.push_back(mk("zero_bypass_rd", 64'd0));
        sb.push_back(mk("zero_bypass_busy", 64'd0));
        #2;
        e = sb.pop_front(); obs = 64'(a_rd_data[31:0]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        e = sb.pop_front(); obs = 64'(a_rd_busy[0]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        tick();
        clear_inputs();
        sb.push_back(mk("zero_stored_rd", 64'd0));
        sb.push_back(mk("zero_busy_vec", 64'd0));
        #2;
        e = sb.pop_front(); obs = 64'(a_rd_data[63:32]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        e = sb.pop_front(); obs = 64'(a_busy_vec); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_dual_write();
        exp_t e;
        logic [63:0] obs;
        a_we0 = 1; a_wa0 = 5'd7; a_wd0 = 32'h1111;
        a_we1 = 1; a_wa1 = 5'd7; a_wd1 = 32'h2222;
        b_we0 = 1; b_wa0 = 5'd7; b_wd0 = 32'h1111;
        b_we1 = 1; b_wa1 = 5'd7; b_wd1 = 32'h2222;
        a_rd_addr = {5'd0, 5'd7};
        b_rd_addr = {5'd7, 5'd0};
        sb.push_back(mk("dual_bypass_a", 64'h2222));
        sb.push_back(mk("dual_nobypass_b", 64'h0));
        #2;
        e = sb.pop_front(); obs = 64'(a_rd_data[31:0]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        e = sb.pop_front(); obs = 64'(b_rd_data[63:32]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        tick();
        clear_inputs();
        sb.push_back(mk("dual_stored_a", 64'h2222));
        sb.push_back(mk("dual_stored_b", 64'h2222));
        #2;
        e = sb.pop_front(); obs = 64'(a_rd_data[31:0]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        e = sb.pop_front(); obs = 64'(b_rd_data[63:32]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_busy();
        exp_t e;
        logic [63:0] obs;
        // Each row: we0, we1, set_busy on reg 9; expected rd_busy now, busy_vec[9] after the edge.
        logic [4:0] rows [3] = '{5'b00111, 5'b10111, 5'b01000};
        a_rd_addr = {5'd9, 5'd3};
        for (int r = 0; r < 3; r++) begin
            a_we0 = rows[r][4]; a_wa0 = 5'd9; a_wd0 = 32'h99;
            a_we1 = rows[r][3]; a_wa1 = 5'd9; a_wd1 = 32'h77;
            a_set_busy = rows[r][2]; a_set_addr = 5'd9;
            sb.push_back(mk("busy_rd_busy", 64'(rows[r][1])));
            #2;
            e = sb.pop_front(); obs = 64'(a_rd_busy[1]); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, r, obs, e.val); end
            tick();
            clear_inputs();
            sb.push_back(mk("busy_vec9", 64'(rows[r][0])));
            e = sb.pop_front(); obs = 64'(a_busy_vec[9]); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, r, obs, e.val); end
        end
        b_rd_addr = {5'd0, 5'd9};
        b_set_busy = 1; b_set_addr = 5'd9;
        sb.push_back(mk("nobyp_busy_before", 64'd0));
        #2;
        e = sb.pop_front(); obs = 64'(b_rd_busy[0]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        tick();
        clear_inputs();
        b_we0 = 1; b_wa0 = 5'd9; b_wd0 = 32'h5;
        sb.push_back(mk("nobyp_busy_stored", 64'd1));
        #2;
        e = sb.pop_front(); obs = 64'(b_rd_busy[0]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        tick();
        clear_inputs();
        sb.push_back(mk("nobyp_busy_cleared", 64'd0));
        #2;
        e = sb.pop_front(); obs = 64'(b_rd_busy[0]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [63:0] obs;
        for (int i = 1; i < 32; i++) begin
            a_we0 = (i % 2 == 1); a_wa0 = 5'(i); a_wd0 = 32'(i) * 32'h0101_0101;
            a_we1 = (i % 2 == 0); a_wa1 = 5'(i); a_wd1 = 32'(i) * 32'h0101_0101;
            tick();
        end
        clear_inputs();
        a_rd_addr = {5'd30, 5'd17};
        sb.push_back(mk("fill_reg17", 64'h1111_1111));
        sb.push_back(mk("fill_reg30", 64'h1E1E_1E1E));
        #2;
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front(); obs = 64'(a_rd_data[k*32 +: 32]); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        end
        a_reset = 1; a_we1 = 1; a_wa1 = 5'd3; a_wd1 = 32'hABCD;
        a_rd_addr = {5'd0, 5'd3};
        sb.push_back(mk("reset_cycle_bypass", 64'hABCD));
        #2;
        e = sb.pop_front(); obs = 64'(a_rd_data[31:0]); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        tick();
        a_reset = 0;
        clear_inputs();
        for (int i = 0; i < 32; i += 2) begin
            a_rd_addr = {5'(i + 1), 5'(i)};
            sb.push_back(mk("post_reset_rd0", 64'd0));
            sb.push_back(mk("post_reset_rd1", 64'd0));
            #2;
            for (int k = 0; k < 2; k++) begin
                e = sb.pop_front(); obs = 64'(a_rd_data[k*32 +: 32]); checks++;
                if (obs !== e.val) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, i + k, obs, e.val); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [63:0] obs;
        for (int n = 0; n < 60; n++) begin
            a_we0 = 1'($urandom_range(0, 1)); a_wa0 = 5'($urandom_range(0, 7)); a_wd0 = $urandom;
            a_we1 = 1'($urandom_range(0, 1)); a_wa1 = 5'($urandom_range(0, 7)); a_wd1 = $urandom;
            a_set_busy = 1'($urandom_range(0, 1)); a_set_addr = 5'($urandom_range(0, 7));
            a_rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            for (int k = 0; k < 2; k++) sb.push_back(mk("rand_rd", 64'(m_rd(a_rd_addr[k*5 +: 5]))));
            for (int k = 0; k < 2; k++) sb.push_back(mk("rand_busy", 64'(m_rb(a_rd_addr[k*5 +: 5]))));
            sb.push_back(mk("rand_busy_vec", 64'(m_busy)));
            #2;
            for (int k = 0; k < 2; k++) begin
                e = sb.pop_front(); obs = 64'(a_rd_data[k*32 +: 32]); checks++;
                if (obs !== e.val) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, n, obs, e.val); end
            end
            for (int k = 0; k < 2; k++) begin
                e = sb.pop_front(); obs = 64'(a_rd_busy[k]); checks++;
                if (obs !== e.val) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, n, obs, e.val); end
            end
            e = sb.pop_front(); obs = 64'(a_busy_vec); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, n, obs, e.val); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_wide();
        exp_t e;
        logic [63:0] obs;
        c_rd_addr = {4'd15, 4'd15, 4'd0};
        c_we0 = 1; c_wa0 = 4'd15; c_wd0 = 64'hFFFF_0000_FFFF_0000;
        sb.push_back(mk("wide_bypass_p0", 64'd0));
        sb.push_back(mk("wide_bypass_p1", 64'hFFFF_0000_FFFF_0000));
        sb.push_back(mk("wide_bypass_p2", 64'hFFFF_0000_FFFF_0000));
        #2;
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front(); obs = c_rd_data[k*64 +: 64]; checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        end
        tick();
        clear_inputs();
        c_rd_addr = {4'd15, 4'd0, 4'd15};
        sb.push_back(mk("wide_stored_p0", 64'hFFFF_0000_FFFF_0000));
        sb.push_back(mk("wide_stored_p1", 64'd0));
        sb.push_back(mk("wide_stored_p2", 64'hFFFF_0000_FFFF_0000));
        #2;
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front(); obs = c_rd_data[k*64 +: 64]; checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_busy = 32'd0;
        a_reset = 0; b_reset = 0; c_reset = 0;
        a_wa0 = 0; a_wa1 = 0; a_wd0 = 0; a_wd1 = 0; a_set_addr = 0; a_rd_addr = 0;
        b_wa0 = 0; b_wa1 = 0; b_wd0 = 0; b_wd1 = 0; b_set_addr = 0; b_rd_addr = 0;
        c_wa0 = 0; c_wa1 = 0; c_wd0 = 0; c_wd1 = 0; c_set_addr = 0; c_rd_addr = 0;
        clear_inputs();
        test_reset();
        test_zero_reg();
        test_dual_write();
        test_busy();
        test_reset_mid();
        test_random();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
